// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine: streams 512-bit blocks, chains the hash across blocks and retires
// ROUNDS_PER_CYCLE rounds per clock. Define SHA256_DOUBLE_EN to add the dbl port and second pass.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  // Handshake: a block transfers on a rising edge where blk_valid and blk_ready are both high;
  // the source holds blk_data/blk_first/blk_last/init_h (and dbl) stable until that edge.
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [15:0][31:0] blk_data,
  input  logic              blk_first,
  input  logic              blk_last,
  input  logic [7:0][31:0]  init_h,
`ifdef SHA256_DOUBLE_EN
  input  logic              dbl,
`endif
  output logic              busy,
  output logic              digest_valid,
  output logic [7:0][31:0]  digest,
  output logic [1:0]        state_dbg
);

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int         RPC  = ROUNDS_PER_CYCLE;
  localparam logic [6:0] STEP = 7'(ROUNDS_PER_CYCLE);

  // Element 0 is the first hash word (6a09e667).
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    ADD   = 2'd2
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state;
  logic [6:0]        cnt;
  logic [6:0]        cnt_nxt;
  logic [15:0][31:0] w_q;
  logic [15:0][31:0] w_nxt;
  logic [7:0][31:0]  work;
  logic [7:0][31:0]  work_nxt;
  logic [7:0][31:0]  h_q;
  logic [7:0][31:0]  h_sum;
  logic              last_q;
  logic [31:0]       ext [16+RPC];
  logic [7:0][31:0]  v;
  logic [31:0]       t1;
  logic [31:0]       t2;
`ifdef SHA256_DOUBLE_EN
  logic              dbl_q;
`endif

  assign cnt_nxt   = cnt + STEP;
  assign blk_ready = (state == IDLE);
  assign busy      = ~blk_ready;
  assign state_dbg = state;

  // RPC rounds chained in one cycle; ext[16..] extends the window so each round has its own word.
  always_comb begin
    v  = work;
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < RPC; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    for (int r = 0; r < RPC; r++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt[5:0] + 6'(r)] + ext[r];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
    work_nxt = v;
    for (int i = 0; i < 16; i++) w_nxt[i] = ext[i+RPC];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + work[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      w_q          <= '0;
      work         <= '0;
      h_q          <= IV;
      last_q       <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
`ifdef SHA256_DOUBLE_EN
      dbl_q        <= 1'b0;
`endif
    end else begin
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            w_q    <= blk_data;
            cnt    <= '0;
            last_q <= blk_last;
`ifdef SHA256_DOUBLE_EN
            dbl_q  <= dbl;
`endif
            if (blk_first) begin
              h_q  <= init_h;
              work <= init_h;
            end else begin
              work <= h_q;
            end
            state <= ROUND;
          end
        end
        ROUND: begin
          work <= work_nxt;
          w_q  <= w_nxt;
          cnt  <= cnt_nxt;
          if (cnt_nxt[6]) state <= ADD;
        end
        ADD: begin
          h_q   <= h_sum;
          state <= IDLE;
          if (last_q) begin
`ifdef SHA256_DOUBLE_EN
            if (dbl_q) begin
              // Second pass hashes the 256-bit first digest as a single padded block.
              dbl_q <= 1'b0;
              w_q   <= {32'h00000100, {6{32'h0}}, 32'h80000000, h_sum};
              h_q   <= IV;
              work  <= IV;
              cnt   <= '0;
              state <= ROUND;
            end else begin
              digest       <= h_sum;
              digest_valid <= 1'b1;
            end
`else
            digest       <= h_sum;
            digest_valid <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: three lanes (1, 4 and 8 rounds per cycle) checked every cycle
// against a textbook SHA-256 model, plus directed digests and latencies from known vectors.
`timescale 1ns/1ps
module tb_sha256_stream_core;

  typedef logic [7:0][31:0]  h_t;
  typedef logic [15:0][31:0] blk_t;
  typedef struct {
    int lane;
    int due;
    h_t dig;
  } exp_t;

  localparam int NL = 3;
`ifdef SHA256_DOUBLE_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] B1W [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };

  localparam logic [255:0] IV_F     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_F    = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_F    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] EMPTY_F  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DEMPTY_F = 256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456;

  // ---------------- clock / reset / DUTs ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  blk_t              blk_data;
  logic              blk_first;
  logic              blk_last;
  logic              dbl;
  h_t                init_h;
  logic              vld [NL];
  logic              rdy [NL];
  logic              bsy [NL];
  logic              dv  [NL];
  h_t                dg  [NL];
  logic [1:0]        st  [NL];
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gl = 0; gl < NL; gl++) begin : g_lane
    sha256_stream_core #(.ROUNDS_PER_CYCLE(gl == 0 ? 1 : (gl == 1 ? 4 : 8))) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .blk_valid    (vld[gl]),
      .blk_ready    (rdy[gl]),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .init_h       (init_h),
`ifdef SHA256_DOUBLE_EN
      .dbl          (dbl),
`endif
      .busy         (bsy[gl]),
      .digest_valid (dv[gl]),
      .digest       (dg[gl]),
      .state_dbg    (st[gl])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic h_t mk_h(input logic [255:0] f);
    h_t r;
    for (int i = 0; i < 8; i++) r[i] = f[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] flat(input h_t h);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[255-32*i -: 32] = h[i];
    return f;
  endfunction

  function automatic h_t compress(input h_t hin, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
    h_t r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; hh = hin[7];
    for (int t = 0; t < 64; t++) begin
      x1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      x2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
    r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + hh;
    return r;
  endfunction

  function automatic blk_t pad256(input h_t h);
    blk_t b = '0;
    for (int i = 0; i < 8; i++) b[i] = h[i];
    b[8]  = 32'h80000000;
    b[15] = 32'h00000100;
    return b;
  endfunction

  function automatic int rounds_of(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 4 : 8);
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input h_t act, input h_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, flat(act), flat(exp), $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  exp_t exp_q[$];
  h_t   mh         [NL];
  h_t   last_dig   [NL];
  int   busy_until [NL];
  logic exp_v;
  logic exp_rdy;
  h_t   hb;
  h_t   hout;
  h_t   hfin;
  int   nn;
  int   e0m;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      for (int l = 0; l < NL; l++) begin
        mh[l]         = mk_h(IV_F);
        last_dig[l]   = '0;
        busy_until[l] = 0;
        chk_bit($sformatf("lane%0d reset digest_valid", l), dv[l], 1'b0);
        chk_bit($sformatf("lane%0d reset blk_ready (state_dbg=%0d)", l, st[l]), rdy[l], 1'b1);
        chk_bit($sformatf("lane%0d reset busy", l), bsy[l], 1'b0);
        chk_h($sformatf("lane%0d reset digest", l), dg[l], '0);
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        exp_rdy = (cyc >= busy_until[l]);
        exp_v   = 1'b0;
        for (int q = 0; q < exp_q.size(); q++) begin
          if (exp_q[q].lane == l && exp_q[q].due == cyc) begin
            exp_v       = 1'b1;
            last_dig[l] = exp_q[q].dig;
            exp_q.delete(q);
            break;
          end
        end
        chk_bit($sformatf("lane%0d digest_valid", l), dv[l], exp_v);
        chk_h($sformatf("lane%0d digest", l), dg[l], last_dig[l]);
        chk_bit($sformatf("lane%0d blk_ready (state_dbg=%0d)", l, st[l]), rdy[l], exp_rdy);
        chk_bit($sformatf("lane%0d busy", l), bsy[l], ~exp_rdy);
        // The offered block transfers on the coming rising edge.
        if (vld[l] && exp_rdy) begin
          e0m  = cyc + 1;
          nn   = 64 / rounds_of(l);
          hb   = blk_first ? init_h : mh[l];
          hout = compress(hb, blk_data);
          if (blk_last && DBL_EN && dbl) begin
            hfin          = compress(mk_h(IV_F), pad256(hout));
            busy_until[l] = e0m + 2 * nn + 2;
            exp_q.push_back('{lane: l, due: e0m + 2 * nn + 2, dig: hfin});
            mh[l]         = hfin;
          end else begin
            busy_until[l] = e0m + nn + 1;
            if (blk_last) exp_q.push_back('{lane: l, due: e0m + nn + 1, dig: hout});
            mh[l]         = hout;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input int l, input blk_t d, input logic f, input logic la,
                       input h_t ih, input logic db, output int e0);
    int k;
    @(posedge clk);
    #1;
    blk_data  = d;
    blk_first = f;
    blk_last  = la;
    init_h    = ih;
    dbl       = db;
    vld[l]    = 1'b1;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (rdy[l]) break;
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL lane%0d accept timeout: got no blk_ready expected blk_ready within 300 cycles", l);
    end
    @(posedge clk);
    #1;
    vld[l] = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_digest(input int l, input int e0, input int lat, input logic [255:0] expf,
                             input string name);
    int k;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (dv[l]) break;
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no digest_valid expected pulse after %0d cycles", name, lat);
    end else begin
      chk_int({name, " latency"}, cyc - e0, lat);
      chk_h({name, " digest"}, dg[l], mk_h(expf));
    end
  endtask

  // ---------------- stimulus ----------------
  blk_t abc_b, empty_b, b1, b2;
  h_t   iv_h, mid_h, junk_h;
  int   ea, eb;

  initial begin
    for (int l = 0; l < NL; l++) vld[l] = 1'b0;
    blk_data = '0; blk_first = 1'b0; blk_last = 1'b0; dbl = 1'b0; init_h = '0;
    abc_b = '0;   abc_b[0] = 32'h61626380; abc_b[15] = 32'h00000018;
    empty_b = '0; empty_b[0] = 32'h80000000;
    for (int i = 0; i < 16; i++) b1[i] = B1W[i];
    b2 = '0;      b2[15] = 32'h000001c0;
    iv_h   = mk_h(IV_F);
    junk_h = mk_h({8{32'hdeadbeef}});
    mid_h  = compress(iv_h, b1);

    // Pin the model itself against published vectors.
    chk_h("model abc", compress(iv_h, abc_b), mk_h(ABC_F));
    chk_h("model two-block", compress(mid_h, b2), mk_h(TWO_F));
    chk_h("model empty", compress(iv_h, empty_b), mk_h(EMPTY_F));
    chk_h("model double empty", compress(iv_h, pad256(compress(iv_h, empty_b))), mk_h(DEMPTY_F));

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    offer(0, abc_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    wait_digest(0, ea, 65, ABC_F, "r1 abc");

    // Two-block message; the second block is held until the core is free again.
    offer(0, b1, 1'b1, 1'b0, iv_h, 1'b0, ea);
    offer(0, b2, 1'b0, 1'b1, junk_h, 1'b0, eb);
    chk_int("r1 block-to-block spacing", eb - ea, 66);
    wait_digest(0, eb, 65, TWO_F, "r1 two-block");

    offer(0, b2, 1'b1, 1'b1, mid_h, 1'b0, ea);
    wait_digest(0, ea, 65, TWO_F, "r1 midstate");

    offer(1, abc_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    wait_digest(1, ea, 17, ABC_F, "r4 abc");
    offer(2, abc_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    wait_digest(2, ea, 9, ABC_F, "r8 abc");

    offer(1, b1, 1'b1, 1'b0, iv_h, 1'b0, ea);
    offer(1, b2, 1'b0, 1'b1, junk_h, 1'b0, eb);
    chk_int("r4 block-to-block spacing", eb - ea, 18);
    wait_digest(1, eb, 17, TWO_F, "r4 two-block");

    // Different block held valid during ROUND of "abc".
    offer(0, abc_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    offer(0, empty_b, 1'b1, 1'b1, iv_h, 1'b0, eb);
    chk_int("r1 held block accept edge", eb - ea, 66);
    wait_digest(0, eb, 65, EMPTY_F, "r1 held empty");

`ifdef SHA256_DOUBLE_EN
    offer(0, empty_b, 1'b1, 1'b1, iv_h, 1'b1, ea);
    wait_digest(0, ea, 130, DEMPTY_F, "r1 double empty");
    offer(1, empty_b, 1'b1, 1'b1, iv_h, 1'b1, ea);
    wait_digest(1, ea, 34, DEMPTY_F, "r4 double empty");
    offer(0, empty_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    wait_digest(0, ea, 65, EMPTY_F, "r1 dbl=0 empty");
`endif

    // Abort mid-block with reset, then hash from the reset H without blk_first.
    offer(0, abc_b, 1'b1, 1'b1, iv_h, 1'b0, ea);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk_bit("post-reset blk_ready", rdy[0], 1'b1);
    offer(0, abc_b, 1'b0, 1'b1, junk_h, 1'b0, ea);
    wait_digest(0, ea, 65, ABC_F, "r1 abc after reset");

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got no end of stimulus expected end before 500000 ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Parametrised SHA-256 compression engine for the bitcoin hashing datapath. It accepts 512-bit message blocks over a valid/ready handshake and chains the intermediate hash across multi-block messages. It retires a configurable number of rounds per clock and emits a one-cycle-valid 256-bit digest after the last block. It replaces the single-block, fixed one-round-per-cycle core and feeds the nonce-search controller.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds retired per clock. Legal values are 1, 2, 4 and 8; any other value is a elaboration error. N = 64/ROUNDS_PER_CYCLE.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `blk_valid` in 1: block offered this cycle.
- `blk_ready` out 1: core can accept a block. Equals (state==IDLE).
- `blk_data` in 16x32: message words. Word 0 is the first scheduled word, big-endian.
- `blk_first` in 1: block starts a new message; the working state is seeded from `init_h`.
- `blk_last` in 1: block ends the message; a digest is produced.
- `init_h` in 8x32: initial hash (standard IV, or a midstate), used when `blk_first`=1.
- `dbl` in 1: double-hash request, sampled with `blk_last`. Present only with `SHA256_DOUBLE_EN`.
- `busy` out 1: complement of `blk_ready`.
- `digest_valid` out 1: one-cycle pulse marking a new `digest`.
- `digest` out 8x32: final hash. Holds its value until the next digest.

## Operation
- States: IDLE, ROUND, ADD.
- **IDLE**
  - On `blk_valid && blk_ready` at a clock edge:
    - W[0..15] <= `blk_data`.
    - If `blk_first`: H[0..7] <= `init_h` and a..h <= `init_h`.
    - Otherwise: a..h <= H, H unchanged.
    - Latch `blk_last` (and `dbl`) internally.
    - Clear the round counter; go to ROUND.
- **ROUND**
  - Each cycle applies ROUNDS_PER_CYCLE chained standard SHA-256 rounds using K[t] and W window word 0.
  - The 16-word schedule window slides by ROUNDS_PER_CYCLE. New words: W16 = σ1(W14)+W9+σ0(W1)+W0.
  - The counter advances by ROUNDS_PER_CYCLE; after N cycles go to ADD.
  - All additions are modulo 2^32. The counter is 7 bits wide and K is indexed 0..63 only.
- **ADD**
  - H[i] <= H[i] + working[i].
  - If the latched last=0: go to IDLE; H is retained for chaining.
  - If last=1 (no double pass): `digest` <= the summed H, `digest_valid` <= 1, go to IDLE.
- An offered block while `blk_ready`=0 is not accepted. The source must hold it.
- `blk_first` and `blk_last` may both be 1 (single-block message).
- `blk_first`=0 with no prior chained block uses the reset value of H: the standard IV 6a09e667…5be0cd19.
- Reset values: state=IDLE, `blk_ready`=1, `busy`=0, `digest_valid`=0, `digest`=0, H=standard IV, W and a..h = 0.
- Reset asserted mid-operation aborts the block immediately; no digest is produced.

## Timing
- Let E0 be the acceptance edge. ROUND occupies edges E1..EN; ADD completes at edge E(N+1).
- `digest_valid` is high for exactly the cycle after E(N+1). `blk_ready` is high in that same cycle.
- Single-pass latency is N+1 cycles: 65 for R=1, 17 for R=4.
- Block-to-block throughput is one block per N+2 cycles.
- The double-hash pass adds N+1 cycles.

## Configuration
- Macro: `SHA256_DOUBLE_EN`.
- **Defined:** the `dbl` port exists.
  - When the latched last=1 and dbl=1, ADD does not output.
  - Instead W <= {summed H[0..7], 32'h80000000, 6×32'h0, 32'h00000100}, and H and a..h <= the standard IV. Go to ROUND for a second pass.
  - The second pass's ADD outputs the digest as normal.
  - Latency is 2N+2 cycles.
- **Undefined:** no `dbl` port, no second pass; behaviour is single-pass only.

## Test plan
- R=1, "abc" padded block, first=last=1, `init_h`=IV -> `digest_valid` high 65 cycles after acceptance; `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- R=1, two-block 448-bit "abcdbcdecdefdefg…nopq" (first then last) -> no pulse after block 1; after block 2, `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- R=4 and R=8, "abc" -> same digest as the R=1 case; pulse at 17 cycles (R=4) and 9 cycles (R=8) after acceptance.
- With `SHA256_DOUBLE_EN`, empty-string block, dbl=1 -> `digest` = 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456 after 2N+2 cycles. With dbl=0 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Hold `blk_valid` high with a different block during ROUND -> `blk_ready`=0; that block is accepted only on the edge after the pulse and yields its own correct digest.
- Pulse `reset_n` low at round 30 of "abc" -> `digest_valid` stays 0 and `blk_ready`=1 after release; a fresh "abc" then produces ba7816bf… correctly.
